// File: rtl/digest_serializer.sv
// digest_serializer: output stage of the SHA-2 core.
// Formats the final hash state (H0..H7) into digest bytes in transmission
// order and streams them out as AXI-Stream beats of M_AXIS_DATA_WIDTH bits,
// with TKEEP on partial beats and TLAST on the final beat of each digest.
// Build option: define DIGEST_BYTE_SWAP_EN for big-endian (standard SHA)
// byte order. Without it, each word's bytes go out little-endian.
module digest_serializer #(
    parameter int M_AXIS_DATA_WIDTH  = 512,
    parameter int S_AXIS_TUSER_WIDTH = 128,
    parameter int M_AXIS_TUSER_WIDTH = 128,
    parameter int SHA_TYPE_LSB       = 32
) (
    input  logic                            axi_aclk,
    input  logic                            axi_resetn,
    input  logic [511:0]                    s_axis_tdata,
    input  logic [S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [31:0]                     digest_count
);

    localparam int BYTES = M_AXIS_DATA_WIDTH / 8;
    // A 512-bit beat is always the whole digest, so the buffer never shifts.
    localparam int SHIFT = (M_AXIS_DATA_WIDTH < 512) ? M_AXIS_DATA_WIDTH : 0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                         r_state;
    logic [3:0]                     r_beat;
    logic [3:0]                     r_nbeats;
    logic [6:0]                     r_rem;
    logic                           r_ready_en;
    logic [31:0]                    r_count;
    logic [511:0]                   r_buf;
    logic [M_AXIS_TUSER_WIDTH-1:0]  r_tuser;

    logic [1:0]                     w_sha_type;
    logic [6:0]                     w_len;
    logic [3:0]                     w_nbeats;
    logic [511:0]                   w_fmt;
    logic [BYTES-1:0]               w_keep;
    logic                           w_send;
    logic                           w_last;
    logic                           w_m_hs;
    logic                           w_load;
    logic                           w_unused;

    // Digest length in bytes for each SHA variant.
    function automatic logic [6:0] digest_len(input logic [1:0] sha_type);
        case (sha_type)
            2'b00:   return 7'd28;
            2'b01:   return 7'd32;
            2'b10:   return 7'd48;
            default: return 7'd64;
        endcase
    endfunction

    // Byte stream D[p] in transmission order; bytes at or past the digest
    // length are forced to zero so partial beats carry clean padding.
    function automatic logic [511:0] format_digest(input logic [511:0] state,
                                                   input logic [1:0]   sha_type);
        logic [511:0] res;
        logic [6:0]   len;
        int           word;
        int           idx;
        int           lsb;
        res = '0;
        len = digest_len(sha_type);
        for (int p = 0; p < 64; p++) begin
            if (sha_type[1]) begin
                word = p / 8;
                idx  = p % 8;
            end else begin
                // Wrap the word index so the select stays in range; those
                // positions are beyond any 32-bit-mode digest and are masked.
                word = (p / 4) % 8;
                idx  = p % 4;
            end
`ifdef DIGEST_BYTE_SWAP_EN
            lsb = 64 * word + 56 - 8 * idx;
`else
            lsb = sha_type[1] ? (64 * word + 8 * idx) : (64 * word + 32 + 8 * idx);
`endif
            if (7'(p) < len) begin
                res[8*p +: 8] = state[lsb +: 8];
            end
        end
        return res;
    endfunction

    assign w_sha_type = s_axis_tuser[SHA_TYPE_LSB +: 2];
    assign w_fmt      = format_digest(s_axis_tdata, w_sha_type);
    assign w_unused   = &{1'b0, s_axis_tlast, s_axis_tuser};

    // Length and beat count of the digest currently offered on the input.
    always_comb begin
        w_len    = digest_len(w_sha_type);
        w_nbeats = 4'((int'(w_len) + BYTES - 1) / BYTES);
    end

    assign w_send = (r_state == SEND);
    assign w_last = (r_beat == r_nbeats - 4'd1);
    assign w_m_hs = w_send & m_axis_tready;
    // Accept a new digest when empty, or in the same cycle the last beat leaves.
    assign s_axis_tready = r_ready_en & (~w_send | (w_m_hs & w_last));
    assign w_load        = s_axis_tvalid & s_axis_tready;

    // Byte-valid mask from the bytes still remaining in the current digest.
    always_comb begin
        w_keep = '0;
        for (int k = 0; k < BYTES; k++) begin
            w_keep[k] = w_send & (7'(k) < r_rem);
        end
    end

    assign m_axis_tvalid = w_send;
    assign m_axis_tlast  = w_send & w_last;
    assign m_axis_tkeep  = w_keep;
    assign m_axis_tdata  = w_send ? r_buf[M_AXIS_DATA_WIDTH-1:0] : '0;
    assign m_axis_tuser  = w_send ? r_tuser : '0;
    assign digest_count  = r_count;

    // Control FSM: load, beat advance, return to idle, digest counter.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state    <= IDLE;
            r_beat     <= 4'd0;
            r_nbeats   <= 4'd0;
            r_rem      <= 7'd0;
            r_ready_en <= 1'b0;
            r_count    <= 32'd0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_m_hs && w_last) begin
                r_count <= r_count + 32'd1;
            end
            if (w_load) begin
                r_state  <= SEND;
                r_beat   <= 4'd0;
                r_nbeats <= w_nbeats;
                r_rem    <= w_len;
            end else if (w_m_hs) begin
                if (w_last) begin
                    r_state <= IDLE;
                end else begin
                    r_beat <= r_beat + 4'd1;
                    r_rem  <= r_rem - 7'(BYTES);
                end
            end
        end
    end

    // Holding buffer: capture on load, shift the next beat down on advance.
    always_ff @(posedge axi_aclk) begin
        if (w_load) begin
            r_buf   <= w_fmt;
            r_tuser <= s_axis_tuser[M_AXIS_TUSER_WIDTH-1:0];
        end else if (w_m_hs && !w_last) begin
            r_buf <= r_buf >> SHIFT;
        end
    end

endmodule

// File: tb/tb_digest_serializer.sv
// Directed bench for digest_serializer: three instances (512/128/64-bit
// beats) share clock, reset and the input hash state.
module tb_digest_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [511:0] s_data;
    logic [127:0] s_user;
    logic         v512, v128, v64;
    logic         r512, r128, r64;
    logic         sr512, sr128, sr64;
    logic [511:0] d512;
    logic [127:0] d128;
    logic [63:0]  d64;
    logic [63:0]  k512;
    logic [15:0]  k128;
    logic [7:0]   k64;
    logic [127:0] u512o, u128o, u64o;
    logic         vo512, vo128, vo64;
    logic         lo512, lo128, lo64;
    logic [31:0]  c512, c128, c64;

    int n_vec = 0;
    int n_err = 0;

    digest_serializer #(.M_AXIS_DATA_WIDTH(512)) u512 (
        .axi_aclk(clk), .axi_resetn(rst_n),
        .s_axis_tdata(s_data), .s_axis_tuser(s_user), .s_axis_tvalid(v512),
        .s_axis_tlast(1'b1), .s_axis_tready(sr512),
        .m_axis_tdata(d512), .m_axis_tkeep(k512), .m_axis_tuser(u512o),
        .m_axis_tvalid(vo512), .m_axis_tready(r512), .m_axis_tlast(lo512),
        .digest_count(c512));

    digest_serializer #(.M_AXIS_DATA_WIDTH(128)) u128 (
        .axi_aclk(clk), .axi_resetn(rst_n),
        .s_axis_tdata(s_data), .s_axis_tuser(s_user), .s_axis_tvalid(v128),
        .s_axis_tlast(1'b1), .s_axis_tready(sr128),
        .m_axis_tdata(d128), .m_axis_tkeep(k128), .m_axis_tuser(u128o),
        .m_axis_tvalid(vo128), .m_axis_tready(r128), .m_axis_tlast(lo128),
        .digest_count(c128));

    digest_serializer #(.M_AXIS_DATA_WIDTH(64)) u64 (
        .axi_aclk(clk), .axi_resetn(rst_n),
        .s_axis_tdata(s_data), .s_axis_tuser(s_user), .s_axis_tvalid(v64),
        .s_axis_tlast(1'b1), .s_axis_tready(sr64),
        .m_axis_tdata(d64), .m_axis_tkeep(k64), .m_axis_tuser(u64o),
        .m_axis_tvalid(vo64), .m_axis_tready(r64), .m_axis_tlast(lo64),
        .digest_count(c64));

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hash state pattern: byte m of word Hi is 8'h{i,m}.
    task automatic fill_pattern();
        for (int i = 0; i < 8; i++)
            for (int m = 0; m < 8; m++)
                s_data[64*i + 8*m +: 8] = 8'(16*i + m);
    endtask

    function automatic logic [127:0] mk_user(input logic [1:0] sha, input logic [31:0] tag);
        logic [127:0] u;
        u = '0;
        u[31:0]   = tag;
        u[33:32]  = sha;
        u[127:96] = ~tag;
        return u;
    endfunction

    // Expected beat b for the pattern hash, given beat width in bytes.
    function automatic logic [511:0] exp_beat(input logic [1:0] sha, input int bytes, input int b);
        logic [511:0] r;
        int n, p, i, j, m;
        r = '0;
        n = (sha == 2'b00) ? 28 : (sha == 2'b01) ? 32 : (sha == 2'b10) ? 48 : 64;
        for (int k = 0; k < bytes; k++) begin
            p = b * bytes + k;
            if (p < n) begin
                if (sha[1]) begin
                    i = p / 8; j = p % 8;
`ifdef DIGEST_BYTE_SWAP_EN
                    m = 7 - j;
`else
                    m = j;
`endif
                end else begin
                    i = p / 4; j = p % 4;
`ifdef DIGEST_BYTE_SWAP_EN
                    m = 7 - j;
`else
                    m = 4 + j;
`endif
                end
                r[8*k +: 8] = 8'(16*i + m);
            end
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        int beat;
        int c;
        logic [31:0] h0_lo_exp;
        logic [31:0] h1_lo_exp;

        rst_n = 1'b0;
        v512 = 1'b0; v128 = 1'b0; v64 = 1'b0;
        r512 = 1'b0; r128 = 1'b0; r64 = 1'b0;
        s_user = '0;
        s_data = '0;
        fill_pattern();
        repeat (3) tick();

        // Reset state
        chk("rst_tvalid", 512'(vo512), 512'(0));
        chk("rst_tdata",  d512, 512'(0));
        chk("rst_tkeep",  512'(k512), 512'(0));
        chk("rst_tlast",  512'(lo512), 512'(0));
        chk("rst_tuser",  512'(u512o), 512'(0));
        chk("rst_count",  512'(c512), 512'(0));
        chk("rst_sready", 512'(sr512), 512'(0));
        rst_n = 1'b1;
        #1;
        chk("rel_sready_first", 512'(sr512), 512'(0));
        tick();
        chk("rel_sready512", 512'(sr512), 512'(1));
        chk("rel_sready128", 512'(sr128), 512'(1));

        // Test 1: W=512, sha 01, one beat
`ifdef DIGEST_BYTE_SWAP_EN
        h0_lo_exp = 32'h67E6096A;
        h1_lo_exp = 32'h14151617;
`else
        h0_lo_exp = 32'h6A09E667;
        h1_lo_exp = 32'h17161514;
`endif
        fill_pattern();
        s_data[63:0] = 64'h6A09E667_F3BCC908;
        s_user = mk_user(2'b01, 32'h1111);
        v512 = 1'b1; r512 = 1'b1;
        tick();
        v512 = 1'b0;
        chk("t1_tvalid", 512'(vo512), 512'(1));
        chk("t1_word0",  512'(d512[31:0]), 512'(h0_lo_exp));
        chk("t1_word1",  512'(d512[63:32]), 512'(h1_lo_exp));
        chk("t1_pad",    512'(d512[511:256]), 512'(0));
        chk("t1_tkeep",  512'(k512), 512'(64'h00000000FFFFFFFF));
        chk("t1_tlast",  512'(lo512), 512'(1));
        chk("t1_tuser",  512'(u512o), 512'(mk_user(2'b01, 32'h1111)));
        tick();
        chk("t1_count",  512'(c512), 512'(1));
        chk("t1_idle",   512'(vo512), 512'(0));

        // Test 2: W=128, sha 00, two beats
        fill_pattern();
        s_user = mk_user(2'b00, 32'h2222);
        v128 = 1'b1; r128 = 1'b1;
        tick();
        v128 = 1'b0;
        chk("t2_b0_data", 512'(d128), exp_beat(2'b00, 16, 0));
        chk("t2_b0_keep", 512'(k128), 512'(16'hFFFF));
        chk("t2_b0_last", 512'(lo128), 512'(0));
        tick();
        chk("t2_b1_data", 512'(d128), exp_beat(2'b00, 16, 1));
        chk("t2_b1_keep", 512'(k128), 512'(16'h0FFF));
        chk("t2_b1_last", 512'(lo128), 512'(1));
        chk("t2_b1_pad",  512'(d128[127:96]), 512'(0));
        tick();
        chk("t2_idle",  512'(vo128), 512'(0));
        chk("t2_count", 512'(c128), 512'(1));

        // Test 3: W=64, sha 10 (6 beats) then sha 11 (8 beats)
        for (int s = 2; s < 4; s++) begin
            s_user = mk_user(2'(s), 32'h3300 + 32'(s));
            v64 = 1'b1; r64 = 1'b1;
            tick();
            v64 = 1'b0;
            nb = (s == 2) ? 6 : 8;
            for (int b = 0; b < nb; b++) begin
                chk("t3_data", 512'(d64), exp_beat(2'(s), 8, b));
                chk("t3_keep", 512'(k64), 512'(8'hFF));
                chk("t3_last", 512'(lo64), 512'(b == nb - 1));
                chk("t3_user", 512'(u64o), 512'(mk_user(2'(s), 32'h3300 + 32'(s))));
                tick();
            end
            chk("t3_idle", 512'(vo64), 512'(0));
        end
        chk("t3_count", 512'(c64), 512'(2));

        // Test 4: W=512, four back-to-back digests
        s_user = mk_user(2'b11, 32'h4400);
        v512 = 1'b1; r512 = 1'b1;
        #1;
        chk("t4_sready_idle", 512'(sr512), 512'(1));
        tick();
        for (int d = 0; d < 4; d++) begin
            chk("t4_tvalid", 512'(vo512), 512'(1));
            chk("t4_tlast",  512'(lo512), 512'(1));
            chk("t4_data",   d512, exp_beat(2'b11, 64, 0));
            chk("t4_tuser",  512'(u512o), 512'(mk_user(2'b11, 32'h4400 + 32'(d))));
            chk("t4_sready", 512'(sr512), 512'(1));
            if (d < 3) s_user = mk_user(2'b11, 32'h4400 + 32'(d + 1));
            else       v512 = 1'b0;
            tick();
        end
        chk("t4_idle",  512'(vo512), 512'(0));
        chk("t4_count", 512'(c512), 512'(5));

        // Test 5: W=128, sha 11, tready pattern 1,0,0,1,...
        s_user = mk_user(2'b11, 32'h5500);
        v128 = 1'b1; r128 = 1'b0;
        tick();
        v128 = 1'b0;
        beat = 0;
        c = 0;
        while (beat < 4 && c < 40) begin
            r128 = (c % 3 == 0);
            #1;
            chk("t5_data",   512'(d128), exp_beat(2'b11, 16, beat));
            chk("t5_keep",   512'(k128), 512'(16'hFFFF));
            chk("t5_last",   512'(lo128), 512'(beat == 3));
            chk("t5_sready", 512'(sr128), 512'(beat == 3 && r128));
            chk("t5_user",   512'(u128o), 512'(mk_user(2'b11, 32'h5500)));
            if (r128) beat++;
            c++;
            tick();
        end
        chk("t5_beats", 512'(beat), 512'(4));
        chk("t5_idle",  512'(vo128), 512'(0));
        chk("t5_count", 512'(c128), 512'(2));

        // Test 6: W=128, reset during beat 2 of 4
        s_user = mk_user(2'b11, 32'h6600);
        v128 = 1'b1; r128 = 1'b1;
        tick();
        v128 = 1'b0;
        chk("t6_b0_data", 512'(d128), exp_beat(2'b11, 16, 0));
        tick();
        chk("t6_b1_data", 512'(d128), exp_beat(2'b11, 16, 1));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 512'(vo128), 512'(0));
        chk("t6_rst_tdata",  512'(d128), 512'(0));
        chk("t6_rst_tkeep",  512'(k128), 512'(0));
        chk("t6_rst_tlast",  512'(lo128), 512'(0));
        chk("t6_rst_tuser",  512'(u128o), 512'(0));
        chk("t6_rst_count",  512'(c128), 512'(0));
        chk("t6_rst_count512", 512'(c512), 512'(0));
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_rel_sready_first", 512'(sr128), 512'(0));
        tick();
        chk("t6_rel_sready", 512'(sr128), 512'(1));
        s_user = mk_user(2'b00, 32'h6601);
        v128 = 1'b1;
        tick();
        v128 = 1'b0;
        chk("t6_new_b0_data", 512'(d128), exp_beat(2'b00, 16, 0));
        chk("t6_new_b0_keep", 512'(k128), 512'(16'hFFFF));
        chk("t6_new_b0_last", 512'(lo128), 512'(0));
        tick();
        chk("t6_new_b1_keep", 512'(k128), 512'(16'h0FFF));
        chk("t6_new_b1_last", 512'(lo128), 512'(1));
        tick();
        chk("t6_new_count", 512'(c128), 512'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
